// File: rtl/pulse_period_meter.sv
// Measures period and high time of an asynchronous pulse train in clk cycles.
// Results go out through a single-entry valid/ready register with a sticky overrun flag.
module pulse_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  input  logic             ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             timeout,
  output logic [CNT_W-1:0] edge_count,
  output logic             o_dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync;
  logic                   w_rise;
  logic                   w_fall;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_high_cand;
  logic [CNT_W-1:0] w_high_cand_nxt;
  logic             r_hi_flag;
  logic             w_hi_flag_nxt;
  logic             w_res_load;
  logic             w_timeout_nxt;
  logic             w_cnt_at_limit;

  logic             r_res_new;
  logic [CNT_W-1:0] r_res_period;
  logic [CNT_W-1:0] r_res_high;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_overrun;
  logic             r_timeout;
  logic [CNT_W-1:0] r_edge_count;
  logic             w_xfer;

  assign w_sync         = r_sync[SYNC_STAGES-1];
  assign w_rise         = w_sync & ~r_hist;
  assign w_fall         = ~w_sync & r_hist;
  assign w_cnt_at_limit = (r_cnt == CNT_W'(TIMEOUT));

  // Handshake: a result is transferred on any cycle where valid && ready are
  // both high at the rising edge; period/high_time are stable while valid is
  // high unless a newer result replaces them (which sets overrun if not taken).
  assign w_xfer = r_valid & ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_high_cand_nxt = r_high_cand;
    w_hi_flag_nxt   = r_hi_flag;
    w_res_load      = 1'b0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt   = MEASURE;
          w_cnt_nxt     = CNT_W'(1);
          w_hi_flag_nxt = 1'b0;
        end
      end
      MEASURE: begin
        // A rise on the very cycle the limit is reached still yields a result.
        if (w_rise) begin
          w_res_load    = 1'b1;
          w_cnt_nxt     = CNT_W'(1);
          w_hi_flag_nxt = 1'b0;
        end else if (w_cnt_at_limit) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_fall && !r_hi_flag) begin
            w_high_cand_nxt = r_cnt;
            w_hi_flag_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sync       <= '0;
      r_hist       <= 1'b0;
      r_cnt        <= '0;
      r_high_cand  <= '0;
      r_hi_flag    <= 1'b0;
      r_timeout    <= 1'b0;
      r_edge_count <= '0;
      r_res_new    <= 1'b0;
      r_res_period <= '0;
      r_res_high   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], signal_in};
      r_hist      <= w_sync;
      r_cnt       <= w_cnt_nxt;
      r_high_cand <= w_high_cand_nxt;
      r_hi_flag   <= w_hi_flag_nxt;
      r_timeout   <= w_timeout_nxt;
      r_res_new   <= w_res_load;
      if (w_rise) begin
        r_edge_count <= r_edge_count + CNT_W'(1);
      end
      if (w_res_load) begin
        r_res_period <= r_cnt;
        r_res_high   <= r_hi_flag ? r_high_cand : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_overrun & ~w_xfer) | (r_res_new & r_valid & ~ready);
      if (r_res_new) begin
        r_period <= r_res_period;
        r_high   <= r_res_high;
        r_valid  <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign period      = r_period;
  assign high_time   = r_high;
  assign valid       = r_valid;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;
  assign edge_count  = r_edge_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: waveform segments drive both the
// DUT and an edge-time reference model that predicts results, timeouts and edges.
module tb_pulse_period_meter;

  localparam int CNT_W       = 32;
  localparam int TIMEOUT     = 1024;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             signal_in;
  logic             ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overrun;
  logic             timeout;
  logic [CNT_W-1:0] edge_count;
  logic             o_dbg_state;

  pulse_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .signal_in  (signal_in),
    .ready      (ready),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .overrun    (overrun),
    .timeout    (timeout),
    .edge_count (edge_count),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {period, high_time}
  logic [2*CNT_W-1:0] exp_q[$];
  logic [2*CNT_W-1:0] obs_q[$];
  int tmo_seen;

  // reference model: absolute edge times in cycles
  int m_t;
  bit m_prev;
  bit m_ref_ok;
  int m_ref;
  bit m_hi_seen;
  int m_hi;
  int m_edges;
  int m_tmo;

  always @(negedge clk) begin
    if (valid && ready) obs_q.push_back({period, high_time});
    if (timeout) tmo_seen++;
  end

  task automatic model_reset();
    m_t = 0; m_prev = 1'b0; m_ref_ok = 1'b0; m_ref = 0;
    m_hi_seen = 1'b0; m_hi = 0; m_edges = 0; m_tmo = 0;
    exp_q.delete(); obs_q.delete(); tmo_seen = 0;
  endtask

  task automatic apply_reset();
    signal_in = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // drive one waveform segment of 'dur' cycles and feed its edge to the model
  task automatic seg(input bit lvl, input int dur);
    if (lvl && !m_prev) begin
      m_edges++;
      if (m_ref_ok) begin
        if (m_t - m_ref <= TIMEOUT)
          exp_q.push_back({CNT_W'(m_t - m_ref), (m_hi_seen ? CNT_W'(m_hi) : CNT_W'(0))});
        else
          m_tmo++;
      end
      m_ref_ok = 1'b1; m_ref = m_t; m_hi_seen = 1'b0;
    end
    if (!lvl && m_prev && m_ref_ok && !m_hi_seen) begin
      m_hi = m_t - m_ref;
      m_hi_seen = 1'b1;
    end
    m_prev = lvl;
    signal_in = lvl;
    repeat (dur) @(posedge clk);
    #1;
    m_t += dur;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0;
    repeat (4) begin
      signal_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    n_checks++;
    if ({period, high_time, valid, overrun, timeout, edge_count, o_dbg_state} !== '0)
      $display("FAIL reset_held got period=%0d high=%0d valid=%0b ovr=%0b tmo=%0b edges=%0d st=%0b exp all 0",
               period, high_time, valid, overrun, timeout, edge_count, o_dbg_state);
    else n_pass++;
    signal_in = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if ({period, high_time, valid, overrun, timeout, edge_count, o_dbg_state} !== '0)
      $display("FAIL reset_release got period=%0d high=%0d valid=%0b edges=%0d exp all 0",
               period, high_time, valid, edge_count);
    else n_pass++;
  endtask

  task automatic test_square();
    logic [2*CNT_W-1:0] e, o;
    logic [CNT_W-1:0] ec0;
    apply_reset(); ready = 1'b1;
    seg(0, 3);
    repeat (6) begin seg(1, 8); seg(0, 8); end
    ec0 = edge_count;
    seg(1, 8); seg(0, 8);
    n_checks++;
    if (edge_count - ec0 !== CNT_W'(1)) $display("FAIL sq_edge_step got %0d exp 1", edge_count - ec0);
    else n_pass++;
    seg(0, 6);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL sq_count got %0d exp %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL sq_result got %0d/%0d exp %0d/%0d", o[63:32], o[31:0], e[63:32], e[31:0]);
      else n_pass++;
    end
    n_checks++;
    if (edge_count !== CNT_W'(m_edges)) $display("FAIL sq_edges got %0d exp %0d", edge_count, m_edges);
    else n_pass++;
  endtask

  task automatic test_latency();
    int n;
    apply_reset(); ready = 1'b1;
    seg(0, 2); seg(1, 4); seg(0, 4);
    signal_in = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (valid) break;
    end
    n_checks++;
    if (n - 1 != SYNC_STAGES + 1) $display("FAIL latency got %0d edges exp %0d", n - 1, SYNC_STAGES + 1);
    else n_pass++;
    n_checks++;
    if ({period, high_time} !== {CNT_W'(8), CNT_W'(4)})
      $display("FAIL latency_result got %0d/%0d exp 8/4", period, high_time);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2*CNT_W-1:0] e, o;
    apply_reset(); ready = 1'b1;
    seg(0, 2);
    repeat (40) begin
      seg(1, $urandom_range(1, 12));
      seg(0, $urandom_range(1, 12));
    end
    seg(0, 8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL rnd_result got %0d/%0d exp %0d/%0d", o[63:32], o[31:0], e[63:32], e[31:0]);
      else n_pass++;
    end
    n_checks++;
    if (edge_count !== CNT_W'(m_edges)) $display("FAIL rnd_edges got %0d exp %0d", edge_count, m_edges);
    else n_pass++;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL rnd_overrun got %0b exp 0", overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    apply_reset(); ready = 1'b0;
    seg(0, 2);
    repeat (3) begin seg(1, 3); seg(0, 5); end
    seg(0, 4);
    n_checks++;
    if ({valid, overrun} !== 2'b11) $display("FAIL ovr_flags got valid=%0b ovr=%0b exp 1/1", valid, overrun);
    else n_pass++;
    n_checks++;
    if ({period, high_time} !== {CNT_W'(8), CNT_W'(3)})
      $display("FAIL ovr_result got %0d/%0d exp 8/3", period, high_time);
    else n_pass++;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    n_checks++;
    if ({valid, overrun} !== 2'b00) $display("FAIL ovr_clear got valid=%0b ovr=%0b exp 0/0", valid, overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [2*CNT_W-1:0] e, o;
    apply_reset(); ready = 1'b1;
    seg(0, 2); seg(1, 8); seg(0, 8); seg(1, 8); seg(0, 4);
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL mid_pre_count got %0d exp 1", obs_q.size());
    else n_pass++;
    apply_reset();
    n_checks++;
    if ({period, high_time, valid, overrun, timeout, edge_count, o_dbg_state} !== '0)
      $display("FAIL mid_reset got period=%0d high=%0d valid=%0b edges=%0d st=%0b exp all 0",
               period, high_time, valid, edge_count, o_dbg_state);
    else n_pass++;
    seg(0, 4); seg(1, 8); seg(0, 8); seg(1, 8); seg(0, 8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL mid_count got %0d exp %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL mid_result got %0d/%0d exp %0d/%0d", o[63:32], o[31:0], e[63:32], e[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset(); ready = 1'b1;
    signal_in = 1'b1;
    n = 0;
    while (n < TIMEOUT + 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (timeout) break;
    end
    n_checks++;
    if (n - 1 != SYNC_STAGES + TIMEOUT) $display("FAIL tmo_time got %0d edges exp %0d", n - 1, SYNC_STAGES + TIMEOUT);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({timeout, valid, o_dbg_state} !== 3'b000)
      $display("FAIL tmo_after got tmo=%0b valid=%0b st=%0b exp 0/0/0", timeout, valid, o_dbg_state);
    else n_pass++;
    repeat (50) @(posedge clk); #1;
    n_checks++;
    if (tmo_seen != 1) $display("FAIL tmo_pulses got %0d exp 1", tmo_seen);
    else n_pass++;
  endtask

  task automatic test_timeout_boundary();
    logic [2*CNT_W-1:0] e, o;
    apply_reset(); ready = 1'b1;
    seg(0, 2);
    seg(1, 4); seg(0, TIMEOUT - 4);
    seg(1, 4); seg(0, TIMEOUT - 3);
    seg(1, 4); seg(0, 10);
    seg(1, 3); seg(0, 8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL bnd_count got %0d exp %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL bnd_result got %0d/%0d exp %0d/%0d", o[63:32], o[31:0], e[63:32], e[31:0]);
      else n_pass++;
    end
    n_checks++;
    if (tmo_seen != m_tmo) $display("FAIL bnd_timeouts got %0d exp %0d", tmo_seen, m_tmo);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [CNT_W-1:0] ec0;
    int a;
    apply_reset(); ready = 1'b1;
    repeat (4) begin
      ec0 = edge_count;
      @(posedge clk);
      a = 2 * int'($urandom_range(7, 9)) + 1;
      #(a);
      signal_in = 1'b1;
      #2;
      signal_in = 1'b0;
      repeat (8) @(posedge clk); #1;
      n_checks++;
      if (edge_count - ec0 > CNT_W'(1)) $display("FAIL glitch_edges got +%0d exp <=1", edge_count - ec0);
      else n_pass++;
      n_checks++;
      if ($isunknown({period, high_time, valid, overrun, timeout, edge_count, o_dbg_state}))
        $display("FAIL glitch_x got unknown outputs exp known");
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; signal_in = 1'b0;
    model_reset();
    test_reset();
    test_square();
    test_latency();
    test_random();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_timeout_boundary();
    test_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning the width of the period, high-time and edge-count registers.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum period in clk cycles before the measurement is abandoned; legal range 2 to 2^CNT_W-1.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on signal_in; minimum 2.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 signal_in  input  1  square or pulse waveform, asynchronous to clk.
REQ-007 ready  input  1  consumer accepts the result when valid && ready.
REQ-008 period  output  CNT_W  clk cycles from one synchronized rising edge to the next.
REQ-009 high_time  output  CNT_W  clk cycles from a synchronized rising edge to the following falling edge.
REQ-010 valid  output  1  period/high_time hold a measurement not yet consumed.
REQ-011 overrun  output  1  sticky: a new measurement replaced an unconsumed one.
REQ-012 timeout  output  1  one-cycle pulse when no rising edge arrives within TIMEOUT cycles.
REQ-013 edge_count  output  CNT_W  total synchronized rising edges since reset; wraps modulo 2^CNT_W.

Function
REQ-014 signal_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = sync & ~hist and fall = ~sync & hist, each true for exactly one cycle.
REQ-015 The FSM SHALL have two states: IDLE (no reference edge) and MEASURE (counting from the last rising edge).
REQ-016 IDLE -> MEASURE on rise, with cycle counter cnt set to 1 and the high-time capture flag cleared; no result is produced.
REQ-017 In MEASURE, cnt SHALL increment by 1 every cycle without rise.
REQ-018 In MEASURE on fall, with the high-time capture flag clear, the block SHALL capture high_candidate = cnt and set the flag; later falls before the next rise are ignored.
REQ-019 In MEASURE on rise, the block SHALL load period = cnt and high_time = high_candidate (0 if no fall was seen), assert valid on the next cycle, restart cnt at 1, clear the flag and stay in MEASURE.
REQ-020 In MEASURE, when cnt reaches TIMEOUT without rise, the block SHALL pulse timeout for one cycle, go to IDLE and leave period/high_time/valid unchanged; cnt never wraps.
REQ-021 If rise and the timeout condition occur in the same cycle, rise SHALL win: a result is produced and no timeout pulse is issued.
REQ-022 Latency: valid SHALL rise SYNC_STAGES+1 clk edges after the edge on which signal_in is first sampled high by the first synchronizer flop.
REQ-023 valid SHALL clear on a cycle with valid && ready and no new result; period/high_time SHALL hold stable while valid is high and no new result arrives.
REQ-024 A new result arriving while valid is high and ready is low SHALL overwrite period/high_time, keep valid high and set overrun.
REQ-025 A new result in the same cycle as a valid && ready transfer SHALL load and keep valid high without setting overrun.
REQ-026 overrun SHALL clear on the cycle after a valid && ready transfer, unless set again that cycle.
REQ-027 edge_count SHALL increment on every rise in any state.

Reset
REQ-028 While rst is high at a clk edge: FSM = IDLE; cnt, period, high_time, edge_count = 0; valid, overrun, timeout = 0; synchronizer and history flops = 0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial count; the first rise after reset only arms MEASURE.

Verification
REQ-030 Square wave, 8 cycles high / 8 low, ready=1 -> from the second rise onward each result is period=16, high_time=8; edge_count increments by 1 per 16 cycles.
REQ-031 Single rise, then signal_in held high, TIMEOUT=1024 -> timeout pulses once, 1024 cycles after the rise is detected; valid stays 0; FSM returns to IDLE.
REQ-032 Square wave with 3/5 high/low, ready=0 for two periods -> overrun=1, period=8, high_time=3 hold the latest values; ready=1 for one cycle -> valid=0 and overrun=0 the next cycle.
REQ-033 rst pulsed for 1 cycle midway through a 16-cycle period -> all outputs 0; next rise gives no result; the following rise gives period=16.
REQ-034 Rise timed so detection coincides with cnt == TIMEOUT -> period=TIMEOUT reported, no timeout pulse.
REQ-035 Single-cycle glitch on signal_in, asynchronous to clk -> edge_count advances by at most 1 and no X values propagate past the synchronizer.
